// File: rtl/axi_mem_responder_if.sv
// AXI4 bus bundle between an external-memory master and axi_mem_responder.
interface axi_mem_responder_if #(
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ID_W   = 1
);
    logic [ID_W-1:0]     s_axi_awid;
    logic [ADDR_W-1:0]   s_axi_awaddr;
    logic [7:0]          s_axi_awlen;
    logic [2:0]          s_axi_awsize;
    logic [1:0]          s_axi_awburst;
    logic                s_axi_awlock;
    logic [3:0]          s_axi_awcache;
    logic [2:0]          s_axi_awprot;
    logic [3:0]          s_axi_awqos;
    logic                s_axi_awvalid;
    logic                s_axi_awready;
    logic [DATA_W-1:0]   s_axi_wdata;
    logic [DATA_W/8-1:0] s_axi_wstrb;
    logic                s_axi_wlast;
    logic                s_axi_wvalid;
    logic                s_axi_wready;
    logic [ID_W-1:0]     s_axi_bid;
    logic [1:0]          s_axi_bresp;
    logic                s_axi_bvalid;
    logic                s_axi_bready;
    logic [ID_W-1:0]     s_axi_arid;
    logic [ADDR_W-1:0]   s_axi_araddr;
    logic [7:0]          s_axi_arlen;
    logic [2:0]          s_axi_arsize;
    logic [1:0]          s_axi_arburst;
    logic                s_axi_arlock;
    logic [3:0]          s_axi_arcache;
    logic [2:0]          s_axi_arprot;
    logic [3:0]          s_axi_arqos;
    logic                s_axi_arvalid;
    logic                s_axi_arready;
    logic [ID_W-1:0]     s_axi_rid;
    logic [DATA_W-1:0]   s_axi_rdata;
    logic [1:0]          s_axi_rresp;
    logic                s_axi_rlast;
    logic                s_axi_rvalid;
    logic                s_axi_rready;

    modport slave (
        input  s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst,
        input  s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos, s_axi_awvalid,
        output s_axi_awready,
        input  s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
        output s_axi_wready,
        output s_axi_bid, s_axi_bresp, s_axi_bvalid,
        input  s_axi_bready,
        input  s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst,
        input  s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos, s_axi_arvalid,
        output s_axi_arready,
        output s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
        input  s_axi_rready
    );

    modport master (
        output s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst,
        output s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos, s_axi_awvalid,
        input  s_axi_awready,
        output s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
        input  s_axi_wready,
        input  s_axi_bid, s_axi_bresp, s_axi_bvalid,
        output s_axi_bready,
        output s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst,
        output s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos, s_axi_arvalid,
        input  s_axi_arready,
        input  s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
        output s_axi_rready
    );
endinterface

// File: rtl/axi_mem_responder.sv
// AXI4 slave word memory: one outstanding burst per direction, independent read and
// write FSMs, one beat per cycle.
module axi_mem_responder #(
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ID_W   = 1
) (
    input logic                clk,
    input logic                rst,
    axi_mem_responder_if.slave axi
);
    localparam int unsigned Depth = 2 ** (ADDR_W - 2);
    localparam int unsigned StrbW = DATA_W / 8;
    localparam logic [1:0]  BurstIncr  = 2'b01;
    localparam logic [1:0]  BurstWrap  = 2'b10;
    localparam logic [1:0]  RespOkay   = 2'b00;
    localparam logic [1:0]  RespSlverr = 2'b10;

    logic [DATA_W-1:0] mem [Depth];

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                    input logic [2:0] size,
                                                    input logic [1:0] burst);
        return (burst == BurstIncr) ? addr + (ADDR_W'(1) << size) : addr;
    endfunction

    // ---------------- write channel ----------------
    typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
    w_state_e          w_state;
    logic [ID_W-1:0]   aw_id;
    logic [ADDR_W-1:0] aw_addr;
    logic [7:0]        aw_len, w_cnt;
    logic [2:0]        aw_size;
    logic [1:0]        aw_burst;
    logic              w_err;
    logic              awready, wready, bvalid;
    logic [1:0]        bresp;
    logic [ID_W-1:0]   bid;

    logic w_fire, w_last_beat, w_lastbad, aw_bad;
    assign w_fire      = wready & axi.s_axi_wvalid;
    assign w_last_beat = (w_cnt == aw_len);
    assign w_lastbad   = (axi.s_axi_wlast != w_last_beat);
    assign aw_bad      = (aw_burst == BurstWrap) || (aw_size > 3'd2);

    always_ff @(posedge clk) begin
        if (!rst) begin
            w_state <= WIdle;
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            bresp   <= RespOkay;
            bid     <= '0;
        end else begin
            unique case (w_state)
                WIdle: begin
                    if (awready && axi.s_axi_awvalid) begin
                        aw_id    <= axi.s_axi_awid;
                        aw_addr  <= axi.s_axi_awaddr;
                        aw_len   <= axi.s_axi_awlen;
                        aw_size  <= axi.s_axi_awsize;
                        aw_burst <= axi.s_axi_awburst;
                        w_cnt    <= 8'd0;
                        w_err    <= 1'b0;
                        awready  <= 1'b0;
                        wready   <= 1'b1;
                        w_state  <= WData;
                    end else begin
                        awready <= 1'b1;
                    end
                end
                WData: begin
                    if (w_fire) begin
                        if (w_lastbad) w_err <= 1'b1;
                        // Beat count alone ends the burst; a misplaced wlast only flags.
                        if (w_last_beat) begin
                            wready  <= 1'b0;
                            bvalid  <= 1'b1;
                            bid     <= aw_id;
                            bresp   <= (w_err || w_lastbad || aw_bad) ? RespSlverr : RespOkay;
                            w_state <= WResp;
                        end else begin
                            w_cnt   <= w_cnt + 8'd1;
                            aw_addr <= next_addr(aw_addr, aw_size, aw_burst);
                        end
                    end
                end
                WResp: begin
                    if (axi.s_axi_bready) begin
                        bvalid  <= 1'b0;
                        awready <= 1'b1;
                        w_state <= WIdle;
                    end
                end
                default: w_state <= WIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst && w_fire && !aw_bad) begin
            for (int i = 0; i < StrbW; i++) begin
                if (axi.s_axi_wstrb[i]) begin
                    mem[aw_addr[ADDR_W-1:2]][8*i +: 8] <= axi.s_axi_wdata[8*i +: 8];
                end
            end
        end
    end

    // ---------------- read channel ----------------
    typedef enum logic {RIdle, RData} r_state_e;
    r_state_e          r_state;
    logic [ADDR_W-1:0] ar_addr;
    logic [7:0]        ar_len, r_cnt;
    logic [2:0]        ar_size;
    logic [1:0]        ar_burst;
    logic              ar_bad;
    logic              arready, rvalid, rlast;
    logic [1:0]        rresp;
    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;

    logic ar_bad_in;
    assign ar_bad_in = (axi.s_axi_arburst == BurstWrap) || (axi.s_axi_arsize > 3'd2);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= RIdle;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rlast   <= 1'b0;
            rresp   <= RespOkay;
            rid     <= '0;
            rdata   <= '0;
        end else begin
            unique case (r_state)
                RIdle: begin
                    if (arready && axi.s_axi_arvalid) begin
                        // Beat 0 is fetched straight from the request address.
                        arready  <= 1'b0;
                        rvalid   <= 1'b1;
                        rid      <= axi.s_axi_arid;
                        rlast    <= (axi.s_axi_arlen == 8'd0);
                        rresp    <= ar_bad_in ? RespSlverr : RespOkay;
                        rdata    <= ar_bad_in ? '0 : mem[axi.s_axi_araddr[ADDR_W-1:2]];
                        r_cnt    <= 8'd0;
                        ar_len   <= axi.s_axi_arlen;
                        ar_size  <= axi.s_axi_arsize;
                        ar_burst <= axi.s_axi_arburst;
                        ar_bad   <= ar_bad_in;
                        ar_addr  <= next_addr(axi.s_axi_araddr, axi.s_axi_arsize,
                                              axi.s_axi_arburst);
                        r_state  <= RData;
                    end else begin
                        arready <= 1'b1;
                    end
                end
                RData: begin
                    if (axi.s_axi_rready) begin
                        if (rlast) begin
                            rvalid  <= 1'b0;
                            rlast   <= 1'b0;
                            arready <= 1'b1;
                            r_state <= RIdle;
                        end else begin
                            r_cnt   <= r_cnt + 8'd1;
                            rlast   <= ((r_cnt + 8'd1) == ar_len);
                            rdata   <= ar_bad ? '0 : mem[ar_addr[ADDR_W-1:2]];
                            ar_addr <= next_addr(ar_addr, ar_size, ar_burst);
                        end
                    end
                end
                default: r_state <= RIdle;
            endcase
        end
    end

    assign axi.s_axi_awready = awready;
    assign axi.s_axi_wready  = wready;
    assign axi.s_axi_bvalid  = bvalid;
    assign axi.s_axi_bresp   = bresp;
    assign axi.s_axi_bid     = bid;
    assign axi.s_axi_arready = arready;
    assign axi.s_axi_rvalid  = rvalid;
    assign axi.s_axi_rlast   = rlast;
    assign axi.s_axi_rresp   = rresp;
    assign axi.s_axi_rid     = rid;
    assign axi.s_axi_rdata   = rdata;

    logic unused_sideband;
    assign unused_sideband = ^{axi.s_axi_awlock, axi.s_axi_awcache, axi.s_axi_awprot,
                               axi.s_axi_awqos, axi.s_axi_arlock, axi.s_axi_arcache,
                               axi.s_axi_arprot, axi.s_axi_arqos};
endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed bench for axi_mem_responder with a word-array reference model and
// response scoreboards.
module tb_axi_mem_responder;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    axi_mem_responder_if #(.ADDR_W(14), .DATA_W(32), .ID_W(1)) bus ();

    axi_mem_responder #(.ADDR_W(14), .DATA_W(32), .ID_W(1)) dut (
        .clk (clk),
        .rst (rst),
        .axi (bus)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic        id;
    } rbeat_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] model [4096];
    rbeat_t      rq [$];
    logic [2:0]  bq [$];
    logic [31:0] wbuf [16];
    logic [3:0]  sbuf [16];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return bus.s_axi_awready;
            1:       return bus.s_axi_wready;
            2:       return bus.s_axi_bvalid;
            3:       return bus.s_axi_arready;
            default: return bus.s_axi_rvalid;
        endcase
    endfunction

    task automatic wait_sig(input int sel, input string tag);
        int waited = 0;
        while (sig(sel) !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (waited == 50) check({tag, "_timeout"}, 64'(sig(sel)), 64'd1);
    endtask

    task automatic do_write(input logic [13:0] addr, input int len, input logic [2:0] size,
                            input logic [1:0] burst, input int wlast_at, input logic id,
                            input int abort_after, input int bhold);
        logic [13:0] a;
        logic        bad;
        logic [2:0]  exp_b;
        bad = (burst == 2'b10) || (size > 3'd2);
        a   = addr;
        @(negedge clk);
        bus.s_axi_awvalid = 1'b1;
        bus.s_axi_awaddr  = addr;
        bus.s_axi_awlen   = 8'(len);
        bus.s_axi_awsize  = size;
        bus.s_axi_awburst = burst;
        bus.s_axi_awid    = id;
        wait_sig(0, "awready");
        @(negedge clk);
        bus.s_axi_awvalid = 1'b0;
        check("wready_after_aw", 64'(bus.s_axi_wready), 64'd1);
        for (int b = 0; b <= len; b++) begin
            if (b == abort_after) begin
                bus.s_axi_wvalid = 1'b0;
                rst = 1'b0;
                @(negedge clk);
                rst = 1'b1;
                check("abort_no_bvalid", 64'(bus.s_axi_bvalid), 64'd0);
                @(negedge clk);
                check("abort_awready", 64'({bus.s_axi_awready, bus.s_axi_bvalid}), 64'b10);
                return;
            end
            bus.s_axi_wvalid = 1'b1;
            bus.s_axi_wdata  = wbuf[b];
            bus.s_axi_wstrb  = sbuf[b];
            bus.s_axi_wlast  = (b == wlast_at);
            wait_sig(1, "wready");
            if (!bad) begin
                for (int i = 0; i < 4; i++)
                    if (sbuf[b][i]) model[a[13:2]][8*i +: 8] = wbuf[b][8*i +: 8];
            end
            if (burst == 2'b01) a = a + (14'd1 << size);
            @(negedge clk);
        end
        bus.s_axi_wvalid = 1'b0;
        bus.s_axi_wlast  = 1'b0;
        bq.push_back({id, (bad || wlast_at != len) ? 2'b10 : 2'b00});
        check("bvalid_after_last_w", 64'(bus.s_axi_bvalid), 64'd1);
        if (bhold > 0) begin
            bus.s_axi_bready = 1'b0;
            repeat (bhold) begin
                @(negedge clk);
                check("b_hold", 64'({bus.s_axi_bvalid, bus.s_axi_awready}), 64'b10);
            end
            bus.s_axi_bready = 1'b1;
        end
        wait_sig(2, "bvalid");
        exp_b = bq.pop_front();
        check("bid_bresp", 64'({bus.s_axi_bid, bus.s_axi_bresp}), 64'(exp_b));
        @(negedge clk);
        check("awready_after_b", 64'(bus.s_axi_awready), 64'd1);
    endtask

    task automatic do_read(input logic [13:0] addr, input int len, input logic [2:0] size,
                           input logic [1:0] burst, input logic id, input bit toggle);
        logic [13:0] a;
        logic        bad;
        int          guard = 0;
        rbeat_t      e;
        bad = (burst == 2'b10) || (size > 3'd2);
        a   = addr;
        for (int b = 0; b <= len; b++) begin
            rq.push_back('{data: bad ? 32'd0 : model[a[13:2]], resp: bad ? 2'b10 : 2'b00,
                           last: (b == len), id: id});
            if (burst == 2'b01) a = a + (14'd1 << size);
        end
        @(negedge clk);
        bus.s_axi_arvalid = 1'b1;
        bus.s_axi_araddr  = addr;
        bus.s_axi_arlen   = 8'(len);
        bus.s_axi_arsize  = size;
        bus.s_axi_arburst = burst;
        bus.s_axi_arid    = id;
        wait_sig(3, "arready");
        @(negedge clk);
        bus.s_axi_arvalid = 1'b0;
        check("rvalid_after_ar", 64'(bus.s_axi_rvalid), 64'd1);
        bus.s_axi_rready = 1'b1;
        while (rq.size() > 0 && guard < 200) begin
            if (toggle) bus.s_axi_rready = ~bus.s_axi_rready;
            if (!toggle) check("r_back_to_back", 64'(bus.s_axi_rvalid), 64'd1);
            if (bus.s_axi_rvalid === 1'b1) begin
                e = rq[0];
                if (bus.s_axi_rready) begin
                    void'(rq.pop_front());
                    check("rbeat", 64'({bus.s_axi_rdata, bus.s_axi_rresp, bus.s_axi_rlast,
                                        bus.s_axi_rid}), 64'(e));
                end else begin
                    check("r_stall_stable", 64'({bus.s_axi_rdata, bus.s_axi_rlast}),
                          64'({e.data, e.last}));
                end
            end
            @(negedge clk);
            guard++;
        end
        if (guard == 200) begin
            check("r_timeout", 64'(rq.size()), 64'd0);
            rq.delete();
        end
        bus.s_axi_rready = 1'b1;
        check("arready_after_r", 64'(bus.s_axi_arready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.s_axi_awid = '0;  bus.s_axi_awaddr = '0; bus.s_axi_awlen = '0;
        bus.s_axi_awsize = '0; bus.s_axi_awburst = '0; bus.s_axi_awlock = '0;
        bus.s_axi_awcache = '0; bus.s_axi_awprot = '0; bus.s_axi_awqos = '0;
        bus.s_axi_awvalid = 1'b0;
        bus.s_axi_wdata = '0; bus.s_axi_wstrb = '0; bus.s_axi_wlast = 1'b0;
        bus.s_axi_wvalid = 1'b0; bus.s_axi_bready = 1'b1;
        bus.s_axi_arid = '0;  bus.s_axi_araddr = '0; bus.s_axi_arlen = '0;
        bus.s_axi_arsize = '0; bus.s_axi_arburst = '0; bus.s_axi_arlock = '0;
        bus.s_axi_arcache = '0; bus.s_axi_arprot = '0; bus.s_axi_arqos = '0;
        bus.s_axi_arvalid = 1'b0; bus.s_axi_rready = 1'b1;

        // Reset values, then both address channels ready right after release.
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              64'({bus.s_axi_awready, bus.s_axi_wready, bus.s_axi_bvalid, bus.s_axi_arready,
                   bus.s_axi_rvalid, bus.s_axi_rlast, bus.s_axi_bresp, bus.s_axi_rresp,
                   bus.s_axi_bid, bus.s_axi_rid, bus.s_axi_rdata}), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 64'({bus.s_axi_awready, bus.s_axi_arready}), 64'b11);

        // Single beat write and read back with ID echo.
        wbuf[0] = 32'hDEADBEEF; sbuf[0] = 4'hF;
        do_write(14'h010, 0, 3'd2, 2'b01, 0, 1'b1, -1, 0);
        do_read(14'h010, 0, 3'd2, 2'b01, 1'b1, 1'b0);

        // Eight-beat INCR burst.
        for (int i = 0; i < 8; i++) begin wbuf[i] = 32'(i); sbuf[i] = 4'hF; end
        do_write(14'h100, 7, 3'd2, 2'b01, 7, 1'b0, -1, 0);
        do_read(14'h100, 7, 3'd2, 2'b01, 1'b0, 1'b0);

        // Partial strobe merge: expect 0x11BB33DD.
        wbuf[0] = 32'h11223344; sbuf[0] = 4'hF;
        do_write(14'h020, 0, 3'd2, 2'b01, 0, 1'b0, -1, 0);
        wbuf[0] = 32'hAABBCCDD; sbuf[0] = 4'b0101;
        do_write(14'h020, 0, 3'd2, 2'b01, 0, 1'b0, -1, 0);
        do_read(14'h020, 0, 3'd2, 2'b01, 1'b0, 1'b0);

        // FIXED burst: all beats land on the same word.
        for (int i = 0; i < 3; i++) begin wbuf[i] = 32'hF0 + 32'(i); sbuf[i] = 4'hF; end
        do_write(14'h080, 2, 3'd2, 2'b00, 2, 1'b0, -1, 0);
        do_read(14'h080, 0, 3'd2, 2'b01, 1'b0, 1'b0);

        // Backpressure on R and B.
        do_read(14'h100, 3, 3'd2, 2'b01, 1'b1, 1'b1);
        wbuf[0] = 32'h0BADF00D; sbuf[0] = 4'hF;
        do_write(14'h040, 0, 3'd2, 2'b01, 0, 1'b0, -1, 5);

        // Error cases.
        for (int i = 0; i < 4; i++) begin wbuf[i] = 32'h5000 + 32'(i); sbuf[i] = 4'hF; end
        do_write(14'h060, 3, 3'd2, 2'b01, 1, 1'b1, -1, 0);
        do_read(14'h100, 3, 3'd2, 2'b10, 1'b0, 1'b0);
        wbuf[0] = 32'h12345678; sbuf[0] = 4'hF;
        do_write(14'h010, 0, 3'd3, 2'b01, 0, 1'b0, -1, 0);
        do_read(14'h010, 0, 3'd2, 2'b01, 1'b0, 1'b0);

        // Reset after 2 of 4 beats, then a clean burst to the same place.
        for (int i = 0; i < 4; i++) begin wbuf[i] = 32'hA0 + 32'(i); sbuf[i] = 4'hF; end
        do_write(14'h200, 3, 3'd2, 2'b01, 3, 1'b0, 2, 0);
        do_read(14'h200, 1, 3'd2, 2'b01, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin wbuf[i] = 32'hC0 + 32'(i); sbuf[i] = 4'hF; end
        do_write(14'h200, 3, 3'd2, 2'b01, 3, 1'b1, -1, 0);
        do_read(14'h200, 3, 3'd2, 2'b01, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
